// File: rtl/folded_threshold_voter.sv
// folded_threshold_voter: threshold voter that folds the popcount of an N-bit
// vote vector over FOLD-bit chunks, with valid/ready handshakes on both sides.
module folded_threshold_voter #(
   parameter int N = 15,
   parameter int FOLD = 4,
   parameter int EARLY_EXIT = 0,
   localparam int CW = $clog2(N + 1),
   localparam int S = (N + FOLD - 1) / FOLD
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  x,
   input  logic [CW-1:0] thr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          y,
   output logic [CW-1:0] count
);
   localparam int IW = S > 1 ? $clog2(S) : 1;
   localparam int PW = S * FOLD;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state;
   logic [PW-1:0] xr;
   logic [CW-1:0] thr_r, acc, pc, acc_next;
   logic [IW-1:0] idx;
   int rem;
   logic stop;
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   // xr shifts down one chunk per cycle, so the current chunk is always its low FOLD bits
   always_comb begin
      pc = '0;
      for (int i = 0; i < FOLD; i++) pc = pc + CW'(xr[i]);
      acc_next = acc + pc;
      rem = (int'(idx) + 1) * FOLD >= N ? 0 : N - (int'(idx) + 1) * FOLD;
      stop = idx == IW'(S - 1) ||
             (EARLY_EXIT != 0 && (acc_next >= thr_r || int'(acc_next) + rem < int'(thr_r)));
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         xr <= '0;
         thr_r <= '0;
         acc <= '0;
         idx <= '0;
         y <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               xr <= PW'(x);
               thr_r <= thr;
               acc <= '0;
               idx <= '0;
               state <= BUSY;
            end
            BUSY: begin
               acc <= acc_next;
               idx <= idx + 1'b1;
               xr <= xr >> FOLD;
               if (stop) begin
                  state <= DONE;
                  y <= acc_next >= thr_r;
                  count <= acc_next;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_folded_threshold_voter.sv
// tb_folded_threshold_voter: directed checks on four voter configurations sharing
// one stimulus bus (u0 15/4 plain, u1 15/4 early exit, u2 12/12, u3 12/4 early exit).
module tb_folded_threshold_voter;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic [14:0] x = '0;
   logic [3:0] thr = '0;
   logic ir[4], ov[4], yo[4];
   logic [3:0] cnt[4];
   int total = 0, bad = 0, cyc = 0;
   int lat[4];
   logic yv[4];
   logic [3:0] cv[4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   folded_threshold_voter #(.N(15), .FOLD(4), .EARLY_EXIT(0)) u0 (.clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(ir[0]), .x(x), .thr(thr), .out_valid(ov[0]),
      .out_ready(out_ready), .y(yo[0]), .count(cnt[0]));
   folded_threshold_voter #(.N(15), .FOLD(4), .EARLY_EXIT(1)) u1 (.clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(ir[1]), .x(x), .thr(thr), .out_valid(ov[1]),
      .out_ready(out_ready), .y(yo[1]), .count(cnt[1]));
   folded_threshold_voter #(.N(12), .FOLD(12), .EARLY_EXIT(0)) u2 (.clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(ir[2]), .x(x[11:0]), .thr(thr), .out_valid(ov[2]),
      .out_ready(out_ready), .y(yo[2]), .count(cnt[2]));
   folded_threshold_voter #(.N(12), .FOLD(4), .EARLY_EXIT(1)) u3 (.clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(ir[3]), .x(x[11:0]), .thr(thr), .out_valid(ov[3]),
      .out_ready(out_ready), .y(yo[3]), .count(cnt[3]));

   // one accepted vector; records per-instance result latency (edges after accept), y and count
   task automatic xact(input logic [14:0] vx, input logic [3:0] vt);
      @(negedge clk);
      x = vx;
      thr = vt;
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      for (int k = 0; k < 4; k++) begin
         lat[k] = 0;
         yv[k] = 0;
         cv[k] = 0;
      end
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++)
            if (lat[k] == 0 && ov[k]) begin
               lat[k] = c;
               yv[k] = yo[k];
               cv[k] = cnt[k];
            end
      end
   endtask

   task automatic test_reset;
      x = 15'h7FFF;
      thr = 4'd1;
      in_valid = 1;
      repeat (3) @(negedge clk);
      in_valid = 0;
      rst = 0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         total++; if (ov[k] !== 1'b0) begin bad++; $display("FAIL reset_out_valid u%0d got=%b exp=0", k, ov[k]); end
         total++; if (yo[k] !== 1'b0) begin bad++; $display("FAIL reset_y u%0d got=%b exp=0", k, yo[k]); end
         total++; if (cnt[k] !== 4'd0) begin bad++; $display("FAIL reset_count u%0d got=%0d exp=0", k, cnt[k]); end
         total++; if (ir[k] !== 1'b1) begin bad++; $display("FAIL reset_in_ready u%0d got=%b exp=1", k, ir[k]); end
      end
   endtask

   task automatic test_reset_mid_busy;
      logic seen;
      @(negedge clk);
      x = 15'h7FFF;
      thr = 4'd8;
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", ir[0]); end
      rst = 1;
      #1;
      total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b exp=1", ir[0]); end
      @(negedge clk);
      rst = 0;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) seen = seen | ov[k];
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_out got=%b exp=0", seen); end
   endtask

   task automatic test_basic;
      xact(15'h00FF, 4'd8);
      total++; if (lat[0] != 4) begin bad++; $display("FAIL basic_ff_lat got=%0d exp=4", lat[0]); end
      total++; if (yv[0] !== 1'b1) begin bad++; $display("FAIL basic_ff_y got=%b exp=1", yv[0]); end
      total++; if (cv[0] !== 4'd8) begin bad++; $display("FAIL basic_ff_count got=%0d exp=8", cv[0]); end
      xact(15'h007F, 4'd8);
      total++; if (lat[0] != 4) begin bad++; $display("FAIL basic_7f_lat got=%0d exp=4", lat[0]); end
      total++; if (yv[0] !== 1'b0) begin bad++; $display("FAIL basic_7f_y got=%b exp=0", yv[0]); end
      total++; if (cv[0] !== 4'd7) begin bad++; $display("FAIL basic_7f_count got=%0d exp=7", cv[0]); end
   endtask

   // strided sweep of the vector space with in_valid/out_ready held high
   task automatic test_sweep_throughput;
      int tprev, t, pc;
      logic [14:0] v;
      logic got;
      tprev = 0;
      @(negedge clk);
      thr = 4'd8;
      in_valid = 1;
      for (int k = 0; k < 2521; k++) begin
         v = 15'(k * 13);
         pc = $countones(v);
         total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL sweep_ready x=%h got=%b exp=1", v, ir[0]); end
         x = v;
         @(negedge clk);
         t = cyc;
         if (k > 0) begin
            total++; if (t - tprev != 6) begin bad++; $display("FAIL sweep_period got=%0d exp=6", t - tprev); end
         end
         tprev = t;
         got = 0;
         for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            got = ov[0];
         end
         total++;
         if (!got) begin bad++; $display("FAIL sweep_timeout x=%h got=0 exp=1", v); end
         else if (yo[0] !== (pc >= 8) || cnt[0] !== 4'(pc)) begin
            bad++;
            $display("FAIL sweep_result x=%h got y=%b count=%0d exp y=%b count=%0d", v, yo[0], cnt[0], pc >= 8, pc);
         end
         @(negedge clk);
      end
      in_valid = 0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_early_exit;
      xact(15'h7FFF, 4'd8);
      total++; if (lat[1] != 2) begin bad++; $display("FAIL ee_7fff_lat got=%0d exp=2", lat[1]); end
      total++; if (yv[1] !== 1'b1) begin bad++; $display("FAIL ee_7fff_y got=%b exp=1", yv[1]); end
      total++; if (cv[1] !== 4'd8) begin bad++; $display("FAIL ee_7fff_count got=%0d exp=8", cv[1]); end
      xact(15'h0000, 4'd8);
      total++; if (lat[1] != 2) begin bad++; $display("FAIL ee_0000_lat got=%0d exp=2", lat[1]); end
      total++; if (yv[1] !== 1'b0) begin bad++; $display("FAIL ee_0000_y got=%b exp=0", yv[1]); end
      total++; if (cv[1] !== 4'd0) begin bad++; $display("FAIL ee_0000_count got=%0d exp=0", cv[1]); end
      xact(15'h0F0F, 4'd8);
      total++; if (lat[1] != 3) begin bad++; $display("FAIL ee_0f0f_lat got=%0d exp=3", lat[1]); end
      total++; if (yv[1] !== 1'b1) begin bad++; $display("FAIL ee_0f0f_y got=%b exp=1", yv[1]); end
      total++; if (cv[1] !== 4'd8) begin bad++; $display("FAIL ee_0f0f_count got=%0d exp=8", cv[1]); end
      total++; if (lat[0] != 4 || cv[0] !== 4'd8) begin bad++; $display("FAIL ee_0f0f_plain got lat=%0d count=%0d exp lat=4 count=8", lat[0], cv[0]); end
   endtask

   task automatic test_backpressure;
      out_ready = 0;
      @(negedge clk);
      x = 15'h00FF;
      thr = 4'd8;
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      repeat (4) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         total++;
         if (ov[0] !== 1'b1 || yo[0] !== 1'b1 || cnt[0] !== 4'd8 || ir[0] !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cycle=%0d got ov=%b y=%b count=%0d rdy=%b exp ov=1 y=1 count=8 rdy=0", c, ov[0], yo[0], cnt[0], ir[0]);
         end
         x = 15'h7FFF;
         in_valid = (c == 3);
         @(negedge clk);
      end
      in_valid = 0;
      out_ready = 1;
      @(negedge clk);
      total++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin bad++; $display("FAIL bp_release got ov=%b rdy=%b exp ov=0 rdy=1", ov[0], ir[0]); end
      total++; if (yo[0] !== 1'b1 || cnt[0] !== 4'd8) begin bad++; $display("FAIL bp_keep got y=%b count=%0d exp y=1 count=8", yo[0], cnt[0]); end
      repeat (3) @(negedge clk);
   endtask

   // thr above N needs an N=12 instance, since a 4-bit thr cannot exceed 15
   task automatic test_thr_bounds;
      xact(15'h5555, 4'd0);
      total++; if (lat[0] != 4 || yv[0] !== 1'b1 || cv[0] !== 4'd8) begin bad++; $display("FAIL thr0_u0 got lat=%0d y=%b count=%0d exp lat=4 y=1 count=8", lat[0], yv[0], cv[0]); end
      total++; if (lat[1] != 1 || yv[1] !== 1'b1 || cv[1] !== 4'd2) begin bad++; $display("FAIL thr0_u1 got lat=%0d y=%b count=%0d exp lat=1 y=1 count=2", lat[1], yv[1], cv[1]); end
      total++; if (lat[2] != 1 || yv[2] !== 1'b1 || cv[2] !== 4'd6) begin bad++; $display("FAIL thr0_u2 got lat=%0d y=%b count=%0d exp lat=1 y=1 count=6", lat[2], yv[2], cv[2]); end
      total++; if (lat[3] != 1 || yv[3] !== 1'b1 || cv[3] !== 4'd2) begin bad++; $display("FAIL thr0_u3 got lat=%0d y=%b count=%0d exp lat=1 y=1 count=2", lat[3], yv[3], cv[3]); end
      xact(15'h5555, 4'd13);
      total++; if (lat[0] != 4 || yv[0] !== 1'b0 || cv[0] !== 4'd8) begin bad++; $display("FAIL thr13_u0 got lat=%0d y=%b count=%0d exp lat=4 y=0 count=8", lat[0], yv[0], cv[0]); end
      total++; if (lat[1] != 2 || yv[1] !== 1'b0 || cv[1] !== 4'd4) begin bad++; $display("FAIL thr13_u1 got lat=%0d y=%b count=%0d exp lat=2 y=0 count=4", lat[1], yv[1], cv[1]); end
      total++; if (lat[2] != 1 || yv[2] !== 1'b0 || cv[2] !== 4'd6) begin bad++; $display("FAIL thrbig_u2 got lat=%0d y=%b count=%0d exp lat=1 y=0 count=6", lat[2], yv[2], cv[2]); end
      total++; if (lat[3] != 1 || yv[3] !== 1'b0 || cv[3] !== 4'd2) begin bad++; $display("FAIL thrbig_u3 got lat=%0d y=%b count=%0d exp lat=1 y=0 count=2", lat[3], yv[3], cv[3]); end
   endtask

   initial begin
      test_reset;
      test_reset_mid_busy;
      test_basic;
      test_sweep_throughput;
      test_early_exit;
      test_backpressure;
      test_thr_bounds;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
